// File: rtl/raster_timing_gen.sv
// raster_timing_gen: free-running raster counters with registered syncs, DE, line/frame strobes and frame count.
// Define RASTER_GEN_CE_EN to add the i_ce pixel clock enable; otherwise every i_clk edge advances.
module raster_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
`ifdef RASTER_GEN_CE_EN
   input  logic        i_ce,
`endif
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic        o_h_sync,
   output logic        o_v_sync,
   output logic        o_de,
   output logic        o_line_start,
   output logic        o_frame_start,
   output logic [15:0] o_frame_count
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [15:0] X_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] Y_LAST = 16'(V_TOTAL - 1);
   localparam logic [15:0] X_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] Y_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_params
      $error("raster_timing_gen: H_TOTAL and V_TOTAL must not exceed 65535");
   end

   logic        adv;
   logic [15:0] nx, ny;
   logic [15:0] x_q, x_d, y_q, y_d, fc_q, fc_d;
   logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;

`ifdef RASTER_GEN_CE_EN
   assign adv = i_ce;
`else
   assign adv = 1'b1;
`endif

   // Outputs are computed from the coordinate being entered, so they line up with o_x/o_y.
   assign nx = (x_q == X_LAST) ? 16'd0 : x_q + 16'd1;
   assign ny = (x_q != X_LAST) ? y_q : (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;

   always_comb begin
      x_d  = adv ? nx : x_q;
      y_d  = adv ? ny : y_q;
      hs_d = adv ? ((nx >= HS_BEG && nx < HS_END) ? SYNC_POL : ~SYNC_POL) : hs_q;
      vs_d = adv ? ((ny >= VS_BEG && ny < VS_END) ? SYNC_POL : ~SYNC_POL) : vs_q;
      de_d = adv ? (nx < X_ACT && ny < Y_ACT) : de_q;
      ls_d = adv && nx == 16'd0;
      fs_d = ls_d && ny == 16'd0;
      fc_d = fs_d ? fc_q + 16'd1 : fc_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_q  <= X_LAST;
         y_q  <= Y_LAST;
         hs_q <= ~SYNC_POL;
         vs_q <= ~SYNC_POL;
         de_q <= 1'b0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
         fc_q <= 16'd0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
         fc_q <= fc_d;
      end
   end

   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_h_sync      = hs_q;
   assign o_v_sync      = vs_q;
   assign o_de          = de_q;
   assign o_line_start  = ls_q;
   assign o_frame_start = fs_q;
   assign o_frame_count = fc_q;
endmodule

// File: tb/tb_raster_timing_gen.sv
// tb_raster_timing_gen: directed table plus step model for a shrunken 16x9 raster (hsync x=10..12, vsync y=5..6).
module tb_raster_timing_gen;
   localparam int HT = 16;
   localparam int VT = 9;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b0;
   logic [15:0] o_x, o_y, o_frame_count;
   logic        o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start;

   raster_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b0)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
`ifdef RASTER_GEN_CE_EN
      .i_ce(ce),
`endif
      .o_x(o_x),
      .o_y(o_y),
      .o_h_sync(o_h_sync),
      .o_v_sync(o_v_sync),
      .o_de(o_de),
      .o_line_start(o_line_start),
      .o_frame_start(o_frame_start),
      .o_frame_count(o_frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [52:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   vecs = 0;
   int   errs = 0;
   int   n = 0;
   int   ti = 0;

   function automatic logic [52:0] pk(int x, int y, bit hs, bit vs, bit de, bit ls, bit fs, int fc);
      return {16'(x), 16'(y), hs, vs, de, ls, fs, 16'(fc)};
   endfunction

   // Independent reference: position derived from the number of advances since reset.
   function automatic logic [52:0] model(int k);
      int p, x, y;
      if (k == 0) return pk(HT - 1, VT - 1, 1, 1, 0, 0, 0, 0);
      p = (k - 1) % FR;
      x = p % HT;
      y = p / HT;
      return pk(x, y, !(x >= 10 && x < 13), !(y >= 5 && y < 7), x < 8 && y < 4,
                x == 0, x == 0 && y == 0, ((k - 1) / FR + 1) % 65536);
   endfunction

   task automatic chk(input string nm, input int k, input logic [52:0] exp);
      logic [52:0] got;
      got = {o_x, o_y, o_h_sync, o_v_sync, o_de, o_line_start, o_frame_start, o_frame_count};
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s step=%0d got x=%0d y=%0d hs/vs/de/ls/fs=%b fc=%0d, expected x=%0d y=%0d hs/vs/de/ls/fs=%b fc=%0d",
                  nm, k, got[52:37], got[36:21], got[20:16], got[15:0],
                  exp[52:37], exp[36:21], exp[20:16], exp[15:0]);
      end
   endtask

   task automatic chk_tbl();
      while (ti < tbl.size() && tbl[ti].n == n) begin
         chk("table", n, tbl[ti].exp);
         ti++;
      end
   endtask

   task automatic adv();
      logic [52:0] e;
      ce = 1'b1;
      @(posedge clk);
      #1;
      n++;
      chk("model", n, model(n));
      chk_tbl();
`ifdef RASTER_GEN_CE_EN
      ce = 1'b0;
      @(posedge clk);
      #1;
      e = model(n);
      e[17:16] = 2'b00;
      chk("ce_hold", n, e);
`endif
   endtask

   initial begin
      logic [52:0] r;
      tbl.push_back('{0,   pk(15, 8, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{1,   pk(0,  0, 1, 1, 1, 1, 1, 1)});
      tbl.push_back('{2,   pk(1,  0, 1, 1, 1, 0, 0, 1)});
      tbl.push_back('{8,   pk(7,  0, 1, 1, 1, 0, 0, 1)});
      tbl.push_back('{9,   pk(8,  0, 1, 1, 0, 0, 0, 1)});
      tbl.push_back('{11,  pk(10, 0, 0, 1, 0, 0, 0, 1)});
      tbl.push_back('{13,  pk(12, 0, 0, 1, 0, 0, 0, 1)});
      tbl.push_back('{14,  pk(13, 0, 1, 1, 0, 0, 0, 1)});
      tbl.push_back('{16,  pk(15, 0, 1, 1, 0, 0, 0, 1)});
      tbl.push_back('{17,  pk(0,  1, 1, 1, 1, 1, 0, 1)});
      tbl.push_back('{65,  pk(0,  4, 1, 1, 0, 1, 0, 1)});
      tbl.push_back('{81,  pk(0,  5, 1, 0, 0, 1, 0, 1)});
      tbl.push_back('{109, pk(12, 6, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{113, pk(0,  7, 1, 1, 0, 1, 0, 1)});
      tbl.push_back('{144, pk(15, 8, 1, 1, 0, 0, 0, 1)});
      tbl.push_back('{145, pk(0,  0, 1, 1, 1, 1, 1, 2)});
      tbl.push_back('{289, pk(0,  0, 1, 1, 1, 1, 1, 3)});
      tbl.push_back('{342, pk(5,  3, 1, 1, 1, 0, 0, 3)});

      repeat (3) @(posedge clk);
      #1;
      chk("reset", 0, model(0));
      chk_tbl();
      rst_n = 1'b1;
      while (n < 342) adv();

      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", 0, model(0));
      @(posedge clk);
      #1;
      chk("rst_hold", 0, model(0));
      rst_n = 1'b1;
      n = 0;
      adv();
      r = pk(0, 0, 1, 1, 1, 1, 1, 1);
      chk("rst_restart", n, r);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
